// File: rtl/undertale_pkg.sv
// Shared game-wide encodings: game states, raster limits and the
// collision-controller FSM type. Imported by the collision controller
// and by the frame tick generator.
package undertale_pkg;

  localparam logic [3:0] ST_MENU   = 4'd0;
  localparam logic [3:0] ST_BATTLE = 4'd1;

  localparam logic [9:0] H_LAST = 10'd639;
  localparam logic [9:0] V_LAST = 10'd479;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    INVULN,
    DEAD
  } coll_state_e;

  // Counter width able to hold n; never below 3 so bit [2] (blink phase)
  // always exists.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 7) ? 3 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: registered one-cycle pulse on the cycle after the raster
// reaches its last pixel (H_LAST, V_LAST). Shared with the sprite movers.
module frame_tick_gen
  import undertale_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       tick
);

  logic tick_q;

  // Flag the last pixel of the frame one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= (x == H_LAST) && (y == V_LAST);
  end

  assign tick = tick_q;

endmodule

// File: rtl/bullet_collision_ctrl.sv
// bullet_collision_ctrl: latches heart/bullet pixel overlaps during BATTLE
// and, at end of frame, applies damage, pulses per-bullet collision flags,
// and runs invulnerability frames and game-over.
// Optional feature: define IFRAME_BLINK_EN to drive heart_blank with a
// 4-frame blink while invulnerable; otherwise heart_blank is 0.
module bullet_collision_ctrl
  import undertale_pkg::*;
#(
  parameter int N_BULLETS = 3,
  parameter int HP_INIT   = 20,
  parameter int DAMAGE    = 4,
  parameter int IFRAMES   = 30,
  parameter int HP_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           state,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 heart_on,
  input  logic [N_BULLETS-1:0] bullet_on,
  output logic [N_BULLETS-1:0] collision,
  output logic [HP_W-1:0]      hp,
  output logic                 hit_pulse,
  output logic                 invuln,
  output logic                 game_over,
  output logic                 heart_blank
);

  localparam int unsigned IFW = cnt_w(IFRAMES);

  localparam logic [HP_W-1:0] HP_RST = HP_W'(HP_INIT);
  localparam logic [HP_W:0]   DMG_X  = (HP_W + 1)'(DAMAGE);
  localparam logic [IFW-1:0]  IFR_LD = IFW'(IFRAMES);
  localparam logic [IFW-1:0]  IFR_1  = IFW'(1);

  coll_state_e          fsm_q, fsm_d;
  logic [HP_W-1:0]      hp_q, hp_d;
  logic [N_BULLETS-1:0] pend_q, pend_d;
  logic [N_BULLETS-1:0] col_q, col_d;
  logic [IFW-1:0]       ifr_q, ifr_d;
  logic                 hit_q, hit_d;
  logic                 go_q, go_d;

  logic                 tick;
  logic [N_BULLETS-1:0] pend_acc;
  logic [HP_W:0]        hp_dif;
  logic [HP_W-1:0]      hp_dmg;
  logic                 in_menu, in_battle;

  frame_tick_gen u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .tick  (tick)
  );

  // Overlap on the tick cycle itself is folded in so it counts for the
  // closing frame. Damage is subtracted one bit wider and clamped at 0.
  assign pend_acc  = pend_q | (bullet_on & {N_BULLETS{heart_on}});
  assign hp_dif    = {1'b0, hp_q} - DMG_X;
  assign hp_dmg    = hp_dif[HP_W] ? '0 : hp_dif[HP_W-1:0];
  assign in_menu   = (state == ST_MENU);
  assign in_battle = (state == ST_BATTLE);

  // Next-state and registered-output logic; game-state changes win over damage.
  always_comb begin
    fsm_d  = fsm_q;
    hp_d   = hp_q;
    pend_d = pend_q;
    ifr_d  = ifr_q;
    col_d  = '0;
    hit_d  = 1'b0;
    go_d   = go_q;
    unique case (fsm_q)
      IDLE: begin
        pend_d = '0;
        ifr_d  = '0;
        if (in_menu) begin
          hp_d = HP_RST;
          go_d = 1'b0;
        end else if (in_battle) begin
          fsm_d = ARMED;
        end
      end
      ARMED: begin
        if (!in_battle) begin
          fsm_d  = IDLE;
          pend_d = '0;
          ifr_d  = '0;
        end else if (tick && (pend_acc != '0)) begin
          col_d  = pend_acc;
          hit_d  = 1'b1;
          hp_d   = hp_dmg;
          pend_d = '0;
          ifr_d  = IFR_LD;
          if (hp_dmg == '0) begin
            fsm_d = DEAD;
            go_d  = 1'b1;
          end else begin
            fsm_d = INVULN;
          end
        end else begin
          pend_d = pend_acc;
        end
      end
      INVULN: begin
        pend_d = '0;
        if (!in_battle) begin
          fsm_d = IDLE;
          ifr_d = '0;
        end else if (tick) begin
          if (ifr_q <= IFR_1) begin
            ifr_d = '0;
            fsm_d = ARMED;
          end else begin
            ifr_d = ifr_q - IFR_1;
          end
        end
      end
      DEAD: begin
        pend_d = '0;
        go_d   = 1'b1;
        if (in_menu) begin
          fsm_d = IDLE;
          ifr_d = '0;
        end else if (tick && (ifr_q != '0)) begin
          // Let the post-hit countdown finish so invuln drops while dead.
          ifr_d = ifr_q - IFR_1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any pending hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      hp_q   <= HP_RST;
      pend_q <= '0;
      col_q  <= '0;
      ifr_q  <= '0;
      hit_q  <= 1'b0;
      go_q   <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      hp_q   <= hp_d;
      pend_q <= pend_d;
      col_q  <= col_d;
      ifr_q  <= ifr_d;
      hit_q  <= hit_d;
      go_q   <= go_d;
    end
  end

  assign collision = col_q;
  assign hp        = hp_q;
  assign hit_pulse = hit_q;
  assign game_over = go_q;
  assign invuln    = (ifr_q != '0);

`ifdef IFRAME_BLINK_EN
  assign heart_blank = invuln & ifr_q[2];
`else
  assign heart_blank = 1'b0;
`endif

endmodule
